memory: RTL and testbench

MEMORY -- requirements
Module: memory

---
 rtl/memory.sv | 32 +++
 tb/tb_memory.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/memory.sv
// Single-port word memory: combinational read, write on rising clk,
// and an asynchronous active-low reset that clears every word.
module memory #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  RW,
    input  logic [DATA_WIDTH-1:0] WriteData,
    input  logic [ADDR_WIDTH-1:0] Address,
    output logic [DATA_WIDTH-1:0] ReadData
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Reset has priority, so a write coinciding with an edge during reset is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (RW) begin
            mem[Address] <= WriteData;
        end
    end

    assign ReadData = mem[Address];

endmodule

// File: tb/tb_memory.sv
// Self-checking bench for memory: directed reset/write sequences, a table of
// vectors, and randomized accesses checked against an array-based model.
`timescale 1ns/1ps
module tb_memory;

    localparam int DW    = 32;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic          clk;
    logic          rst_n;
    logic          RW;
    logic [DW-1:0] WriteData;
    logic [AW-1:0] Address;
    logic [DW-1:0] ReadData;

    memory #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .RW       (RW),
        .WriteData(WriteData),
        .Address  (Address),
        .ReadData (ReadData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [DW-1:0] model [DEPTH];
    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic          rw;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [AW-1:0] raddr;
        logic [DW-1:0] exp;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic read_check(input string name, input logic [AW-1:0] a);
        Address = a;
        #1;
        check(name, ReadData, model[a]);
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        RW = 1'b1;
        Address = a;
        WriteData = d;
        @(posedge clk);
        #1;
        if (rst_n) model[a] = d;
        RW = 1'b0;
    endtask

    task automatic clear_model();
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        RW = 1'b0;
        WriteData = '0;
        Address = '0;
        clear_model();

        // Reset held for two cycles, then sweep every address
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < DEPTH; i++) begin
            Address = AW'(i);
            #1;
            check("reset_sweep", ReadData, 32'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Single write
        do_write(4'd1, 32'd42);
        Address = 4'd1; #1; check("single_wr_a1", ReadData, 32'd42);
        Address = 4'd0; #1; check("single_wr_a0", ReadData, 32'd0);
        Address = 4'd2; #1; check("single_wr_a2", ReadData, 32'd0);

        // Full sweep write/readback, then hold RW=0 for 3 edges
        for (int i = 0; i < DEPTH; i++) do_write(AW'(i), DW'(i) * 32'h01010101);
        RW = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            Address = AW'(i);
            #1;
            check("sweep_read", ReadData, DW'(i) * 32'h01010101);
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < DEPTH; i++) begin
            Address = AW'(i);
            #1;
            check("sweep_hold", ReadData, DW'(i) * 32'h01010101);
        end

        // Table-driven overwrite / isolation / no-write vectors
        vecs[0] = '{rw: 1'b1, addr: 4'd15, wdata: 32'hFFFFFFFF, raddr: 4'd15, exp: 32'hFFFFFFFF};
        vecs[1] = '{rw: 1'b1, addr: 4'd15, wdata: 32'h12345678, raddr: 4'd15, exp: 32'h12345678};
        vecs[2] = '{rw: 1'b0, addr: 4'd0,  wdata: 32'hAAAAAAAA, raddr: 4'd0,  exp: 32'h00000000};
        vecs[3] = '{rw: 1'b0, addr: 4'd7,  wdata: 32'hDEADBEEF, raddr: 4'd7,  exp: 32'h07070707};
        vecs[4] = '{rw: 1'b1, addr: 4'd8,  wdata: 32'h80000001, raddr: 4'd9,  exp: 32'h09090909};
        vecs[5] = '{rw: 1'b1, addr: 4'd8,  wdata: 32'h80000001, raddr: 4'd8,  exp: 32'h80000001};
        for (int v = 0; v < 6; v++) begin
            @(negedge clk);
            RW = vecs[v].rw;
            Address = vecs[v].addr;
            WriteData = vecs[v].wdata;
            @(posedge clk);
            #1;
            if (vecs[v].rw) model[vecs[v].addr] = vecs[v].wdata;
            RW = 1'b0;
            Address = vecs[v].raddr;
            #1;
            check($sformatf("vec%0d", v), ReadData, vecs[v].exp);
        end

        // Asynchronous reset mid-cycle, no clock edge needed
        @(posedge clk);
        Address = 4'd5;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_now", ReadData, 32'h0);
        clear_model();
        for (int i = 0; i < DEPTH; i++) read_check("async_rst_sweep", AW'(i));
        @(negedge clk);
        RW = 1'b1;
        Address = 4'd4;
        WriteData = 32'hFFFF0000;
        @(posedge clk);
        #1;
        check("wr_in_reset", ReadData, 32'h0);
        RW = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("after_release", ReadData, 32'h0);
        do_write(4'd4, 32'hCAFEF00D);
        Address = 4'd4; #1; check("first_wr_after_rst", ReadData, 32'hCAFEF00D);

        // Read-during-write on address 3
        do_write(4'd3, 32'd5);
        @(negedge clk);
        RW = 1'b1;
        Address = 4'd3;
        WriteData = 32'd9;
        #1;
        check("rdw_before", ReadData, 32'd5);
        @(posedge clk);
        #1;
        model[3] = 32'd9;
        check("rdw_after", ReadData, 32'd9);
        RW = 1'b0;

        // Randomized accesses against the array model
        for (int n = 0; n < 300; n++) begin
            logic          rw;
            logic [AW-1:0] a;
            logic [DW-1:0] d;
            logic [AW-1:0] other;
            rw = 1'($urandom_range(0, 1));
            a = AW'($urandom_range(0, DEPTH - 1));
            d = $urandom;
            other = AW'($urandom_range(0, DEPTH - 1));
            @(negedge clk);
            RW = rw;
            Address = a;
            WriteData = d;
            #1;
            check("rand_before", ReadData, model[a]);
            @(posedge clk);
            #1;
            if (rw) model[a] = d;
            check("rand_after", ReadData, model[a]);
            RW = 1'b0;
            read_check("rand_other", other);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
